// File: rtl/alu_pkg.sv
// Shared encodings for the ALU and its two-requester arbiter front end.
// Holds select codes, branch condition codes, FSM states and the grant helper.
package alu_pkg;

  localparam logic [3:0] SelAnd    = 4'b0000;
  localparam logic [3:0] SelOr     = 4'b0001;
  localparam logic [3:0] SelAdd    = 4'b0010;
  localparam logic [3:0] SelXor    = 4'b0011;
  localparam logic [3:0] SelSub    = 4'b0100;
  localparam logic [3:0] SelSll    = 4'b0101;
  localparam logic [3:0] SelSrl    = 4'b0110;
  localparam logic [3:0] SelSra    = 4'b0111;
  localparam logic [3:0] SelSlt    = 4'b1000;
  localparam logic [3:0] SelSltu   = 4'b1001;
  localparam logic [3:0] SelBranch = 4'b1010;

  localparam logic [2:0] F3Beq  = 3'b000;
  localparam logic [2:0] F3Bne  = 3'b001;
  localparam logic [2:0] F3Blt  = 3'b100;
  localparam logic [2:0] F3Bge  = 3'b101;
  localparam logic [2:0] F3Bltu = 3'b110;
  localparam logic [2:0] F3Bgeu = 3'b111;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StExec = 2'b01,
    StResp = 2'b10
  } arb_state_e;

  // One-hot grant; on a tie the requester that did not win last time goes first.
  function automatic logic [1:0] rr_pick(input logic [1:0] valid, input logic last_id);
    logic [1:0] pick;
    case (valid)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = last_id ? 2'b01 : 2'b10;
      default: pick = 2'b00;
    endcase
    return pick;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU: logic, arithmetic, shifts, set-less-than and branch compare.
// Flags are {cf, zf, vf, sf}; cf is carry-out on add and borrow on subtract.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned n = 32
) (
  input  logic [n-1:0] i_a,
  input  logic [n-1:0] i_b,
  input  logic [3:0]   i_sel,
  input  logic [4:0]   i_shamt,
  input  logic [2:0]   i_funct3,
  output logic [n-1:0] o_result,
  output logic         o_cf,
  output logic         o_zf,
  output logic         o_vf,
  output logic         o_sf,
  output logic         o_branch_taken
);

  logic [n:0] w_sum;
  logic [n:0] w_diff;
  logic       w_eq;
  logic       w_lt_s;
  logic       w_lt_u;

  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};
  assign w_eq   = (i_a == i_b);
  assign w_lt_s = ($signed(i_a) < $signed(i_b));
  assign w_lt_u = (i_a < i_b);

  always_comb begin
    o_result       = '0;
    o_cf           = 1'b0;
    o_vf           = 1'b0;
    o_branch_taken = 1'b0;
    case (i_sel)
      SelAnd: o_result = i_a & i_b;
      SelOr:  o_result = i_a | i_b;
      SelXor: o_result = i_a ^ i_b;
      SelAdd: begin
        o_result = w_sum[n-1:0];
        o_cf     = w_sum[n];
        o_vf     = (i_a[n-1] == i_b[n-1]) && (w_sum[n-1] != i_a[n-1]);
      end
      SelSub: begin
        o_result = w_diff[n-1:0];
        o_cf     = w_diff[n];
        o_vf     = (i_a[n-1] != i_b[n-1]) && (w_diff[n-1] != i_a[n-1]);
      end
      SelSll:  o_result = i_a << i_shamt;
      SelSrl:  o_result = i_a >> i_shamt;
      SelSra:  o_result = $signed(i_a) >>> i_shamt;
      SelSlt:  o_result = {{(n-1){1'b0}}, w_lt_s};
      SelSltu: o_result = {{(n-1){1'b0}}, w_lt_u};
      SelBranch: begin
        case (i_funct3)
          F3Beq:   o_branch_taken = w_eq;
          F3Bne:   o_branch_taken = ~w_eq;
          F3Blt:   o_branch_taken = w_lt_s;
          F3Bge:   o_branch_taken = ~w_lt_s;
          F3Bltu:  o_branch_taken = w_lt_u;
          F3Bgeu:  o_branch_taken = ~w_lt_u;
          default: o_branch_taken = 1'b0;
        endcase
      end
      default: o_result = '0;
    endcase
  end

  assign o_zf = (o_result == '0);
  assign o_sf = o_result[n-1];

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single shared ALU.
// One operation in flight: grant/capture, execute/register, hold response until taken.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [2*N-1:0] req_a,
  input  logic [2*N-1:0] req_b,
  input  logic [7:0]     req_sel,
  input  logic [9:0]     req_shamt,
  input  logic [5:0]     req_funct3,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [N-1:0]   rsp_result,
  output logic [3:0]     rsp_flags,
  output logic           rsp_branch
);

  arb_state_e r_state;
  arb_state_e w_state_next;
  logic       r_last;
  logic [1:0] w_grant;
  logic       w_grant_id;
  logic       w_accept;

  logic [N-1:0] r_a;
  logic [N-1:0] r_b;
  logic [3:0]   r_sel;
  logic [4:0]   r_shamt;
  logic [2:0]   r_funct3;
  logic         r_id;

  logic [N-1:0] r_result;
  logic [3:0]   r_flags;
  logic         r_branch;
  logic         r_rsp_id;

  logic [N-1:0] w_result;
  logic         w_cf;
  logic         w_zf;
  logic         w_vf;
  logic         w_sf;
  logic         w_branch;

  always_comb begin
    w_state_next = r_state;
    w_grant      = 2'b00;
    unique case (r_state)
      StIdle: begin
        w_grant = rr_pick(req_valid, r_last);
        if (w_grant != 2'b00) begin
          w_state_next = StExec;
        end
      end
      StExec: w_state_next = StResp;
      StResp: begin
        if (rsp_ready) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Gate with reset so nothing is accepted in a cycle whose edge discards it.
  assign req_ready  = rst ? 2'b00 : w_grant;
  assign w_accept   = |req_ready;
  assign w_grant_id = w_grant[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_last <= w_grant_id;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_sel    <= '0;
      r_shamt  <= '0;
      r_funct3 <= '0;
      r_id     <= 1'b0;
    end else if (w_accept) begin
      r_a      <= w_grant_id ? req_a[2*N-1:N]   : req_a[N-1:0];
      r_b      <= w_grant_id ? req_b[2*N-1:N]   : req_b[N-1:0];
      r_sel    <= w_grant_id ? req_sel[7:4]     : req_sel[3:0];
      r_shamt  <= w_grant_id ? req_shamt[9:5]   : req_shamt[4:0];
      r_funct3 <= w_grant_id ? req_funct3[5:3]  : req_funct3[2:0];
      r_id     <= w_grant_id;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= '0;
      r_flags  <= '0;
      r_branch <= 1'b0;
      r_rsp_id <= 1'b0;
    end else if (r_state == StExec) begin
      r_result <= w_result;
      r_flags  <= {w_cf, w_zf, w_vf, w_sf};
      r_branch <= w_branch;
      r_rsp_id <= r_id;
    end
  end

  alu #(
    .n(N)
  ) u_alu (
    .i_a           (r_a),
    .i_b           (r_b),
    .i_sel         (r_sel),
    .i_shamt       (r_shamt),
    .i_funct3      (r_funct3),
    .o_result      (w_result),
    .o_cf          (w_cf),
    .o_zf          (w_zf),
    .o_vf          (w_vf),
    .o_sf          (w_sf),
    .o_branch_taken(w_branch)
  );

  assign rsp_valid  = (r_state == StResp);
  assign rsp_id     = r_rsp_id;
  assign rsp_result = r_result;
  assign rsp_flags  = r_flags;
  assign rsp_branch = r_branch;

endmodule
